// File: rtl/lsu_bus.sv
// lsu_bus: multi-cycle load/store unit between the core and a variable-latency data bus.
// Latency: 3 cycles minimum (IDLE accept, BUSY with ack, RESP); each extra BUSY cycle adds one.
// Backpressure: STALL holds the core until RESP; the bus wait is bounded by TIMEOUT_CYCLES.
//
// Ports:
//   CLK, RESET           clock, asynchronous active-high reset
//   MEM_REQ, MEM_WRITE   core access request (held until DONE or EXC), 1=store
//   f3, addr, store_data RISC-V funct3 size/sign, byte address, rs2 value
//   load_data            extended load result, valid while DONE=1 (0 for stores/timeouts)
//   STALL, DONE, EXC     core hold, completion pulse, misaligned/illegal access flag
//   BUS_ERR              qualifies DONE: transaction timed out
//   bus_*                registered single-request data bus (word address, byte enables)
module lsu_bus #(
   parameter int unsigned TIMEOUT_CYCLES = 255
) (
   input  logic        CLK,
   input  logic        RESET,
   input  logic        MEM_REQ,
   input  logic        MEM_WRITE,
   input  logic [2:0]  f3,
   input  logic [31:0] addr,
   input  logic [31:0] store_data,
   output logic [31:0] load_data,
   output logic        STALL,
   output logic        DONE,
   output logic        EXC,
   output logic        BUS_ERR,
   output logic        bus_req,
   output logic        bus_we,
   output logic [31:0] bus_addr,
   output logic [31:0] bus_wdata,
   output logic [3:0]  bus_be,
   input  logic        bus_ack,
   input  logic [31:0] bus_rdata
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_BUSY = 2'd1,
      S_RESP = 2'd2
   } state_t;

   // Last counter value of the wait window; the counter reads 0 in the first BUSY cycle.
   localparam logic [15:0] TMO_LAST = 16'(TIMEOUT_CYCLES - 1);

   state_t      state;
   state_t      state_nxt;
   logic        legal;
   logic        accept;
   logic        ack_hit;
   logic        tmo_hit;
   logic [15:0] cnt;
   logic [2:0]  f3_q;
   logic [1:0]  lo_q;
   logic [3:0]  be_nxt;
   logic [31:0] wdata_nxt;
   logic [7:0]  byte_sel;
   logic [15:0] half_sel;
   logic [31:0] load_fmt;

   // Access legality: size/alignment and which funct3 codes a store may use.
   always_comb begin
      legal = 1'b0;
      case (f3)
         3'b000: legal = 1'b1;
         3'b001: legal = ~addr[0];
         3'b010: legal = (addr[1:0] == 2'b00);
         3'b100: legal = ~MEM_WRITE;
         3'b101: legal = ~MEM_WRITE & ~addr[0];
         default: legal = 1'b0;
      endcase
   end

   // Byte lanes and replicated write data; loads use the same enables with zero data.
   always_comb begin
      be_nxt    = 4'b1111;
      wdata_nxt = store_data;
      case (f3[1:0])
         2'b00: begin
            be_nxt    = 4'b0001 << addr[1:0];
            wdata_nxt = {4{store_data[7:0]}};
         end
         2'b01: begin
            be_nxt    = addr[1] ? 4'b1100 : 4'b0011;
            wdata_nxt = {2{store_data[15:0]}};
         end
         default: begin
            be_nxt    = 4'b1111;
            wdata_nxt = store_data;
         end
      endcase
      if (!MEM_WRITE) begin
         wdata_nxt = 32'h0;
      end
   end

   // Load extraction from the latched low address bits and funct3.
   always_comb begin
      byte_sel = bus_rdata[7:0];
      case (lo_q)
         2'b00: byte_sel = bus_rdata[7:0];
         2'b01: byte_sel = bus_rdata[15:8];
         2'b10: byte_sel = bus_rdata[23:16];
         default: byte_sel = bus_rdata[31:24];
      endcase
      half_sel = lo_q[1] ? bus_rdata[31:16] : bus_rdata[15:0];
      load_fmt = bus_rdata;
      case (f3_q)
         3'b000: load_fmt = {{24{byte_sel[7]}}, byte_sel};
         3'b001: load_fmt = {{16{half_sel[15]}}, half_sel};
         3'b100: load_fmt = {24'h0, byte_sel};
         3'b101: load_fmt = {16'h0, half_sel};
         default: load_fmt = bus_rdata;
      endcase
   end

   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         state <= S_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      STALL     = 1'b0;
      EXC       = 1'b0;
      accept    = 1'b0;
      ack_hit   = 1'b0;
      tmo_hit   = 1'b0;
      case (state)
         S_IDLE: begin
            if (MEM_REQ) begin
               if (legal) begin
                  accept    = 1'b1;
                  STALL     = 1'b1;
                  state_nxt = S_BUSY;
               end else begin
                  EXC = 1'b1;
               end
            end
         end
         S_BUSY: begin
            STALL = 1'b1;
            // Ack wins over a timeout landing on the same edge.
            if (bus_ack && bus_req) begin
               ack_hit   = 1'b1;
               state_nxt = S_RESP;
            end else if (cnt == TMO_LAST) begin
               tmo_hit   = 1'b1;
               state_nxt = S_RESP;
            end
         end
         S_RESP: begin
            // STALL low here lets the core retire the access on this edge.
            state_nxt = S_IDLE;
         end
         default: state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         bus_req   <= 1'b0;
         bus_we    <= 1'b0;
         bus_addr  <= 32'h0;
         bus_wdata <= 32'h0;
         bus_be    <= 4'h0;
         f3_q      <= 3'b000;
         lo_q      <= 2'b00;
         cnt       <= 16'h0;
         DONE      <= 1'b0;
         BUS_ERR   <= 1'b0;
         load_data <= 32'h0;
      end else begin
         bus_req <= (state_nxt == S_BUSY);
         DONE    <= (state_nxt == S_RESP);

         if (accept) begin
            f3_q      <= f3;
            lo_q      <= addr[1:0];
            bus_addr  <= {addr[31:2], 2'b00};
            bus_we    <= MEM_WRITE;
            bus_be    <= be_nxt;
            bus_wdata <= wdata_nxt;
         end

         if (state == S_BUSY) begin
            cnt <= cnt + 16'd1;
         end else begin
            cnt <= 16'h0;
         end

         if (ack_hit) begin
            BUS_ERR   <= 1'b0;
            load_data <= bus_we ? 32'h0 : load_fmt;
         end else if (tmo_hit) begin
            BUS_ERR   <= 1'b1;
            load_data <= 32'h0;
         end else if (state == S_RESP) begin
            BUS_ERR <= 1'b0;
         end
      end
   end

endmodule
